// File: rtl/tqvp_seq_alu_pkg.sv
// rtl/tqvp_seq_alu_pkg.sv - shared types and constants for tqvp_seq_alu (honours TQVP_SEQ_ALU_MUL_EN)
package tqvp_seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  localparam logic [3:0] ADDR_A_LO     = 4'h0;
  localparam logic [3:0] ADDR_A_HI     = 4'h1;
  localparam logic [3:0] ADDR_B_LO     = 4'h2;
  localparam logic [3:0] ADDR_B_HI     = 4'h3;
  localparam logic [3:0] ADDR_RES_LO   = 4'h4;
  localparam logic [3:0] ADDR_RES_HI   = 4'h5;
  localparam logic [3:0] ADDR_RESHI_LO = 4'h6;
  localparam logic [3:0] ADDR_RESHI_HI = 4'h7;
  localparam logic [3:0] ADDR_CTRL     = 4'h8;
  localparam logic [3:0] ADDR_STATUS   = 4'h9;
  localparam logic [3:0] ADDR_ID       = 4'hF;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_CARRY   = 2;
  localparam int ST_ZERO    = 3;
  localparam int ST_OVERRUN = 4;
  localparam int ST_ERR     = 5;

  localparam int CTRL_START = 7;

`ifdef TQVP_SEQ_ALU_MUL_EN
  localparam logic MUL_PRESENT = 1'b1;
`else
  localparam logic MUL_PRESENT = 1'b0;
`endif

endpackage

// File: rtl/tqvp_seq_alu_if.sv
// rtl/tqvp_seq_alu_if.sv - byte-wide register bus between host and tqvp_seq_alu
interface tqvp_seq_alu_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_seq_alu_mul.sv
// rtl/tqvp_seq_alu_mul.sv - shift-add multiplier, one multiplier bit per cycle (used under TQVP_SEQ_ALU_MUL_EN)
module tqvp_seq_alu_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  // product is exposed one step early so the caller can latch it on the final edge
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign done     = running && (cnt == LAST);

  // load operands on start, then accumulate one partial product per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end
endmodule

// File: rtl/tqvp_seq_alu.sv
// rtl/tqvp_seq_alu.sv - register-mapped sequential ALU top; TQVP_SEQ_ALU_MUL_EN adds the multiplier
module tqvp_seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ui_in,
  output logic [7:0]    uo_out,
  tqvp_seq_alu_if.slave bus
);
  import tqvp_seq_alu_pkg::*;

  localparam int SW = $clog2(WIDTH);

  logic [15:0]      reg_a, reg_b, res, res_hi;
  logic [2:0]       ctrl_op;
  logic             done, carry, zero, overrun, err;
  logic [WIDTH-1:0] w_a, w_b;
  op_e              w_op;
  state_e           state, state_next;
  logic             start_wr, start_go, leave;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_carry;
  logic [WIDTH:0]   sum;
  logic             unused;

  assign unused   = &{1'b0, ui_in};
  assign start_wr = bus.data_write && (bus.address == ADDR_CTRL) && bus.data_in[CTRL_START];
  assign uo_out   = {6'b0, done, 1'b0};

`ifdef TQVP_SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_done;

  tqvp_seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start_go && (bus.data_in[2:0] == OP_MUL)),
    .a       (reg_a[WIDTH-1:0]),
    .b       (reg_b[WIDTH-1:0]),
    .product (mul_prod),
    .done    (mul_done)
  );
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // next state: accept a start in IDLE, leave EXEC after one cycle or when the multiplier finishes
  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    leave      = 1'b0;
    case (state)
      S_IDLE: if (start_wr) begin
        start_go   = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
`ifdef TQVP_SEQ_ALU_MUL_EN
        if ((w_op != OP_MUL) || mul_done) begin
          leave      = 1'b1;
          state_next = S_IDLE;
        end
`else
        leave      = 1'b1;
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // result datapath on the snapshotted operands
  always_comb begin
    sum       = {1'b0, w_a} + {1'b0, w_b};
    alu_res   = '0;
    alu_hi    = '0;
    alu_carry = 1'b0;
    case (w_op)
      OP_ADD: {alu_carry, alu_res} = sum;
      OP_SUB: begin
        alu_res   = w_a - w_b;
        alu_carry = (w_a < w_b);
      end
      OP_AND: alu_res = w_a & w_b;
      OP_OR:  alu_res = w_a | w_b;
      OP_XOR: alu_res = w_a ^ w_b;
      OP_SHL: alu_res = w_a << w_b[SW-1:0];
      OP_SHR: alu_res = w_a >> w_b[SW-1:0];
`ifdef TQVP_SEQ_ALU_MUL_EN
      OP_MUL: begin
        alu_res = mul_prod[WIDTH-1:0];
        alu_hi  = mul_prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  // register writes, op snapshot and status flags; a flag set on the same edge beats a W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a   <= '0;
      reg_b   <= '0;
      res     <= '0;
      res_hi  <= '0;
      ctrl_op <= '0;
      done    <= 1'b0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      overrun <= 1'b0;
      err     <= 1'b0;
      w_a     <= '0;
      w_b     <= '0;
      w_op    <= OP_ADD;
    end else begin
      if (bus.data_write) begin
        case (bus.address)
          ADDR_A_LO:   reg_a[7:0] <= bus.data_in;
          ADDR_A_HI:   if (WIDTH == 16) reg_a[15:8] <= bus.data_in;
          ADDR_B_LO:   reg_b[7:0] <= bus.data_in;
          ADDR_B_HI:   if (WIDTH == 16) reg_b[15:8] <= bus.data_in;
          ADDR_CTRL:   ctrl_op <= bus.data_in[2:0];
          ADDR_STATUS: begin
            if (bus.data_in[ST_DONE])    done    <= 1'b0;
            if (bus.data_in[ST_OVERRUN]) overrun <= 1'b0;
            if (bus.data_in[ST_ERR])     err     <= 1'b0;
          end
          default: ;
        endcase
      end
      if (start_go) begin
        w_a  <= reg_a[WIDTH-1:0];
        w_b  <= reg_b[WIDTH-1:0];
        w_op <= op_e'(bus.data_in[2:0]);
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (start_wr && (state == S_EXEC)) overrun <= 1'b1;
      if (leave) begin
        done <= 1'b1;
`ifndef TQVP_SEQ_ALU_MUL_EN
        if (w_op == OP_MUL) err <= 1'b1;
        else
`endif
        begin
          res    <= 16'(alu_res);
          res_hi <= 16'(alu_hi);
          carry  <= alu_carry;
          zero   <= (alu_res == '0);
        end
      end
    end
  end

  // combinational register read mux
  always_comb begin
    bus.data_out = 8'h00;
    case (bus.address)
      ADDR_A_LO:     bus.data_out = reg_a[7:0];
      ADDR_A_HI:     bus.data_out = reg_a[15:8];
      ADDR_B_LO:     bus.data_out = reg_b[7:0];
      ADDR_B_HI:     bus.data_out = reg_b[15:8];
      ADDR_RES_LO:   bus.data_out = res[7:0];
      ADDR_RES_HI:   bus.data_out = res[15:8];
      ADDR_RESHI_LO: bus.data_out = res_hi[7:0];
      ADDR_RESHI_HI: bus.data_out = res_hi[15:8];
      ADDR_CTRL:     bus.data_out = {5'b0, ctrl_op};
      ADDR_STATUS:   bus.data_out = {2'b00, err, overrun, zero, carry, done, (state == S_EXEC)};
      ADDR_ID:       bus.data_out = {3'b000, MUL_PRESENT, 4'(WIDTH / 8)};
      default:       bus.data_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_tqvp_seq_alu.sv
// tb/tb_tqvp_seq_alu.sv - scoreboard bench for tqvp_seq_alu at WIDTH 16 and 8 (honours TQVP_SEQ_ALU_MUL_EN)
module tb_tqvp_seq_alu;
  localparam logic [3:0] A_LO = 4'h0, A_HI = 4'h1, B_LO = 4'h2, B_HI = 4'h3;
  localparam logic [3:0] R_LO = 4'h4, R_HI = 4'h5, H_LO = 4'h6, H_HI = 4'h7;
  localparam logic [3:0] CTRL = 4'h8, STAT = 4'h9, IDR = 4'hF;
`ifdef TQVP_SEQ_ALU_MUL_EN
  localparam logic [7:0] ID16 = 8'h12, ID8 = 8'h11;
`else
  localparam logic [7:0] ID16 = 8'h02, ID8 = 8'h01;
`endif

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo16, uo8;
  logic       chk_valid = 1'b0;
  sb_t        sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  tqvp_seq_alu_if bus16 ();
  tqvp_seq_alu_if bus8 ();

  tqvp_seq_alu #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo16), .bus(bus16));
  tqvp_seq_alu #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo8),  .bus(bus8));

  always #5 clk = ~clk;

  // sel 0: 16-bit data_out, 1: 16-bit uo_out, 2: 8-bit data_out, 3: 8-bit uo_out
  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: read strobe with no expected entry");
      end else begin
        sb_t        e;
        logic [7:0] act;
        e = sb_q.pop_front();
        case (e.sel)
          0:       act = bus16.data_out;
          1:       act = uo16;
          2:       act = bus8.data_out;
          default: act = uo8;
        endcase
        n_cmp++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr(input int sel, input logic [3:0] a, input logic [7:0] d);
    if (sel >= 2) begin
      bus8.address = a; bus8.data_in = d; bus8.data_write = 1'b1;
    end else begin
      bus16.address = a; bus16.data_in = d; bus16.data_write = 1'b1;
    end
    @(posedge clk); #1;
    bus16.data_write = 1'b0;
    bus8.data_write  = 1'b0;
  endtask

  task automatic chk(input int sel, input logic [3:0] a, input logic [7:0] e, input string nm);
    sb_t t;
    if (sel >= 2) bus8.address = a;
    else          bus16.address = a;
    t.name = nm; t.sel = sel; t.exp = e;
    sb_q.push_back(t);
    chk_valid = 1'b1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus16.address = '0; bus16.data_in = '0; bus16.data_write = 1'b0;
    bus8.address  = '0; bus8.data_in  = '0; bus8.data_write  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk(0, STAT, 8'h00, "rst_status");
    chk(1, STAT, 8'h00, "rst_uo_out");
    chk(0, IDR,  ID16,  "id16");
    rst = 1'b0;
    cyc(1);

    // ADD 0xFFFF + 0x0001
    wr(0, A_LO, 8'hFF); wr(0, A_HI, 8'hFF); wr(0, B_LO, 8'h01); wr(0, B_HI, 8'h00);
    wr(0, CTRL, 8'h80);
    chk(0, STAT, 8'h01, "add_busy");
    chk(0, STAT, 8'h0E, "add_status");
    chk(0, R_LO, 8'h00, "add_res_lo");
    chk(0, R_HI, 8'h00, "add_res_hi");
    chk(1, STAT, 8'h02, "add_uo_done");

    // SUB 3 - 5, then W1C done
    wr(0, A_LO, 8'h03); wr(0, A_HI, 8'h00); wr(0, B_LO, 8'h05);
    wr(0, CTRL, 8'h81);
    chk(0, STAT, 8'h0D, "sub_busy");
    chk(0, STAT, 8'h06, "sub_status");
    chk(0, R_LO, 8'hFE, "sub_res_lo");
    chk(0, R_HI, 8'hFF, "sub_res_hi");
    chk(0, CTRL, 8'h01, "ctrl_opcode_read");
    wr(0, STAT, 8'h02);
    chk(0, STAT, 8'h04, "w1c_done");
    chk(1, STAT, 8'h00, "uo_after_w1c");

    // MUL 0x1234 * 0x0100
    wr(0, A_LO, 8'h34); wr(0, A_HI, 8'h12); wr(0, B_LO, 8'h00); wr(0, B_HI, 8'h01);
    wr(0, CTRL, 8'h87);
`ifdef TQVP_SEQ_ALU_MUL_EN
    for (int i = 0; i < 16; i++) chk(0, STAT, 8'h05, $sformatf("mul_busy_%0d", i));
    chk(0, STAT, 8'h02, "mul_status");
    chk(0, R_LO, 8'h00, "mul_res_lo");
    chk(0, R_HI, 8'h34, "mul_res_hi");
    chk(0, H_LO, 8'h12, "mul_reshi_lo");
    chk(0, H_HI, 8'h00, "mul_reshi_hi");
    wr(0, STAT, 8'h32);
    chk(0, STAT, 8'h00, "mul_clear");

    // start during MUL: overrun, operand/opcode writes do not disturb the op
    wr(0, CTRL, 8'h87);
    wr(0, A_LO, 8'h00); wr(0, A_HI, 8'h00);
    wr(0, CTRL, 8'h80);
    chk(0, STAT, 8'h11, "ovr_busy");
    cyc(12);
    chk(0, STAT, 8'h12, "ovr_status");
    chk(0, R_LO, 8'h00, "ovr_res_lo");
    chk(0, R_HI, 8'h34, "ovr_res_hi");
    chk(0, H_LO, 8'h12, "ovr_reshi_lo");
    chk(0, CTRL, 8'h00, "ovr_ctrl_updated");
    chk(0, A_HI, 8'h00, "ovr_a_updated");
`else
    chk(0, STAT, 8'h05, "mul_busy");
    chk(0, STAT, 8'h26, "mul_err_status");
    chk(0, R_LO, 8'hFE, "mul_res_lo_kept");
    chk(0, R_HI, 8'hFF, "mul_res_hi_kept");
    chk(0, H_LO, 8'h00, "mul_reshi_lo");
    wr(0, STAT, 8'h32);
    chk(0, STAT, 8'h04, "mul_clear");

    // start while EXEC: overrun, second start ignored
    wr(0, CTRL, 8'h80);
    wr(0, CTRL, 8'h81);
    chk(0, STAT, 8'h12, "ovr_status");
    chk(0, R_LO, 8'h34, "ovr_res_lo");
    chk(0, R_HI, 8'h13, "ovr_res_hi");
    chk(0, STAT, 8'h12, "ovr_no_restart");
`endif
    wr(0, STAT, 8'h32);

    // reset in the middle of EXEC
    wr(0, A_LO, 8'h05); wr(0, B_LO, 8'h03);
    wr(0, CTRL, 8'h87);
`ifdef TQVP_SEQ_ALU_MUL_EN
    chk(0, STAT, 8'h01, "pre_rst_busy");
    cyc(3);
`endif
    rst = 1'b1;
    chk(0, STAT, 8'h00, "rst_mid_status");
    chk(0, A_LO, 8'h00, "rst_mid_a");
    chk(0, B_HI, 8'h00, "rst_mid_b");
    chk(0, R_HI, 8'h00, "rst_mid_res");
    chk(0, H_LO, 8'h00, "rst_mid_reshi");
    chk(0, CTRL, 8'h00, "rst_mid_ctrl");
    chk(1, STAT, 8'h00, "rst_mid_uo");
    rst = 1'b0;
    cyc(20);
    chk(0, STAT, 8'h00, "no_done_after_rst");
    chk(0, R_LO, 8'h00, "no_res_after_rst");

    // WIDTH=8: SHL by 9 mod 8, upper bytes inert
    wr(2, A_LO, 8'h81); wr(2, A_HI, 8'hFF); wr(2, B_LO, 8'h09); wr(2, B_HI, 8'hFF);
    wr(2, CTRL, 8'h85);
    chk(2, STAT, 8'h01, "w8_shl_busy");
    chk(2, STAT, 8'h02, "w8_shl_status");
    chk(2, R_LO, 8'h02, "w8_shl_res");
    chk(2, A_HI, 8'h00, "w8_addr1");
    chk(2, B_HI, 8'h00, "w8_addr3");
    chk(2, R_HI, 8'h00, "w8_addr5");
    chk(2, H_HI, 8'h00, "w8_addr7");
    chk(2, IDR,  ID8,   "id8");
    chk(3, STAT, 8'h02, "w8_uo_done");

    // WIDTH=8: ADD wraps with carry and zero
    wr(2, A_LO, 8'hFF); wr(2, B_LO, 8'h01);
    wr(2, CTRL, 8'h80);
    chk(2, STAT, 8'h01, "w8_add_busy");
    chk(2, STAT, 8'h0E, "w8_add_status");
    chk(2, R_LO, 8'h00, "w8_add_res");

    cyc(2);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
